// File: rtl/color_pkg.sv
// Shared definitions for the digit colour encoder.
//   - state_e     : FSM state encoding (idle / converting / result held)
//   - palette12() : decimal digit -> 12-bit RGB colour (4 bits per channel)
//   - expand24()  : 12-bit colour -> 24-bit colour by replicating each nibble
//   - max_value() : largest value representable in a given number of decimal digits
package color_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [11:0] PAL_0 = 12'h000;
    localparam logic [11:0] PAL_1 = 12'hF00;
    localparam logic [11:0] PAL_2 = 12'hF80;
    localparam logic [11:0] PAL_3 = 12'hFF0;
    localparam logic [11:0] PAL_4 = 12'h0F0;
    localparam logic [11:0] PAL_5 = 12'h0FF;
    localparam logic [11:0] PAL_6 = 12'h08F;
    localparam logic [11:0] PAL_7 = 12'h00F;
    localparam logic [11:0] PAL_8 = 12'hF0F;
    localparam logic [11:0] PAL_9 = 12'hFFF;

    function automatic logic [11:0] palette12(input logic [3:0] digit);
        logic [11:0] c;
        case (digit)
            4'd0:    c = PAL_0;
            4'd1:    c = PAL_1;
            4'd2:    c = PAL_2;
            4'd3:    c = PAL_3;
            4'd4:    c = PAL_4;
            4'd5:    c = PAL_5;
            4'd6:    c = PAL_6;
            4'd7:    c = PAL_7;
            4'd8:    c = PAL_8;
            4'd9:    c = PAL_9;
            default: c = 12'h000; // non-BCD codes cannot occur; keep them dark
        endcase
        return c;
    endfunction

    function automatic logic [23:0] expand24(input logic [11:0] c12);
        return {c12[11:8], c12[11:8], c12[7:4], c12[7:4], c12[3:0], c12[3:0]};
    endfunction

    function automatic longint unsigned max_value(input int digits);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more so
// that the following left shift carries correctly into the next decimal digit.
//   d : BCD nibble before correction
//   q : corrected nibble
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/digit_color_encoder.sv
// Sequential binary-to-colour-digit encoder. A value accepted on the input
// handshake is converted to DIGITS decimal digits by iterative double-dabble
// (one input bit per cycle), and each digit is mapped to a palette colour.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_value is the unsigned binary value
//   out_valid/out_ready : output handshake for code/ovf
//   code                : DIGITS colours, most significant digit in the top slice
//   ovf                 : input exceeded 10**DIGITS-1 (all digits then show 9)
module digit_color_encoder
    import color_pkg::*;
#(
    parameter int unsigned IN_W    = 6,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned COLOR_W = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DIGITS*COLOR_W-1:0]   code,
    output logic                        ovf
);

    localparam int unsigned CNT_W   = $clog2(IN_W + 1);
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam logic [63:0] MAX_VAL = 64'(max_value(DIGITS));

    state_e                      state_q;
    logic [IN_W-1:0]             shift_q;
    logic [BCD_W-1:0]            bcd_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        ovf_q;
    logic                        out_valid_q;
    logic [DIGITS*COLOR_W-1:0]   code_q;

    logic [BCD_W-1:0]            bcd_adj;
    logic [BCD_W-1:0]            bcd_next;
    logic [IN_W-1:0]             shift_next;
    logic [DIGITS*COLOR_W-1:0]   code_next;
    logic [63:0]                 in_ext;
    logic                        ovf_cmp;

    assign in_ext  = 64'(in_value);
    assign ovf_cmp = (in_ext > MAX_VAL);

    // One double-dabble step: correct every nibble, then shift {bcd, shift} left.
    // Bits pushed out of the top BCD nibble are dropped; ovf covers that case.
    assign bcd_next   = {bcd_adj[BCD_W-2:0], shift_q[IN_W-1]};
    assign shift_next = shift_q << 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] nib_adj;
        logic [3:0] digit;

        bcd_add3 u_bcd_add3 (
            .d (bcd_q[4*g +: 4]),
            .q (nib_adj)
        );

        assign bcd_adj[4*g +: 4] = nib_adj;
        // code_next is only captured on the last step, so bcd_next holds final digits
        assign digit = ovf_q ? 4'd9 : bcd_next[4*g +: 4];

        if (COLOR_W == 24) begin : g_c24
            assign code_next[COLOR_W*g +: COLOR_W] = expand24(palette12(digit));
        end else begin : g_c12
            assign code_next[COLOR_W*g +: COLOR_W] = COLOR_W'(palette12(digit));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q <= in_value;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(IN_W);
                        ovf_q   <= ovf_cmp;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    shift_q <= shift_next;
                    bcd_q   <= bcd_next;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        code_q      <= code_next;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // code/ovf stay untouched here so they hold under backpressure
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign code      = code_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_color_encoder.sv
// Directed, table-driven bench for digit_color_encoder. Three instances cover
// the default configuration, a wider input (IN_W=8) and 24-bit colours.
module tb_digit_color_encoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: defaults (IN_W=6, DIGITS=2, COLOR_W=12)
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a;
    logic [5:0]  in_value_a;
    logic [23:0] code_a;

    // Instance B: IN_W=8
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b;
    logic [7:0]  in_value_b;
    logic [23:0] code_b;

    // Instance C: COLOR_W=24
    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, ovf_c;
    logic [5:0]  in_value_c;
    logic [47:0] code_c;

    digit_color_encoder dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_value(in_value_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .code(code_a), .ovf(ovf_a)
    );

    digit_color_encoder #(.IN_W(8), .DIGITS(2), .COLOR_W(12)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_value(in_value_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .code(code_b), .ovf(ovf_b)
    );

    digit_color_encoder #(.IN_W(6), .DIGITS(2), .COLOR_W(24)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_value(in_value_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .code(code_c), .ovf(ovf_c)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]  value;
        logic [23:0] code;
        logic        ovf;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rd_in_ready(input int sel);
        case (sel)
            0:       return in_ready_a;
            1:       return in_ready_b;
            default: return in_ready_c;
        endcase
    endfunction

    function automatic logic rd_out_valid(input int sel);
        case (sel)
            0:       return out_valid_a;
            1:       return out_valid_b;
            default: return out_valid_c;
        endcase
    endfunction

    function automatic logic rd_ovf(input int sel);
        case (sel)
            0:       return ovf_a;
            1:       return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic logic [63:0] rd_code(input int sel);
        case (sel)
            0:       return 64'(code_a);
            1:       return 64'(code_b);
            default: return 64'(code_c);
        endcase
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [63:0] value);
        case (sel)
            0: begin in_valid_a = v; in_value_a = value[5:0]; end
            1: begin in_valid_b = v; in_value_b = value[7:0]; end
            default: begin in_valid_c = v; in_value_c = value[5:0]; end
        endcase
    endtask

    task automatic drive_ready(input int sel, input logic r);
        case (sel)
            0:       out_ready_a = r;
            1:       out_ready_b = r;
            default: out_ready_c = r;
        endcase
    endtask

    // One full transfer: accept, wait for the result, optional backpressure, handshake.
    // exp_lat counts edges after the accepting edge until out_valid is seen.
    task automatic xfer(input int sel, input logic [63:0] value, input logic [63:0] exp_code,
                        input logic exp_ovf, input int exp_lat, input int hold, input string nm);
        int   edges;
        logic busy_bad;
        logic stable_bad;
        @(negedge clk);
        drive_in(sel, 1'b1, value);
        check({nm, " in_ready before accept"}, 64'(rd_in_ready(sel)), 64'd1);
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, value);
        edges    = 0;
        busy_bad = 1'b0;
        while (!rd_out_valid(sel) && edges < 40) begin
            if (rd_in_ready(sel)) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        check({nm, " latency"}, 64'(edges), 64'(exp_lat));
        check({nm, " code"}, rd_code(sel), exp_code);
        check({nm, " ovf"}, 64'(rd_ovf(sel)), 64'(exp_ovf));
        check({nm, " in_ready in DONE"}, 64'(rd_in_ready(sel)), 64'd0);
        check({nm, " in_ready low while busy"}, 64'(busy_bad), 64'd0);
        if (hold > 0) begin
            stable_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (rd_code(sel) !== exp_code || rd_ovf(sel) !== exp_ovf ||
                    rd_out_valid(sel) !== 1'b1 || rd_in_ready(sel) !== 1'b0) begin
                    stable_bad = 1'b1;
                end
            end
            check({nm, " stable under backpressure"}, 64'(stable_bad), 64'd0);
        end
        @(negedge clk);
        drive_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_ready(sel, 1'b0);
        check({nm, " out_valid after handshake"}, 64'(rd_out_valid(sel)), 64'd0);
        check({nm, " in_ready after handshake"}, 64'(rd_in_ready(sel)), 64'd1);
    endtask

    initial begin
        logic seen_valid;

        vecs[0] = '{value: 6'd37, code: 24'hFF0_00F, ovf: 1'b0, hold: 0};
        vecs[1] = '{value: 6'd0,  code: 24'h000_000, ovf: 1'b0, hold: 0};
        vecs[2] = '{value: 6'd63, code: 24'h08F_FF0, ovf: 1'b0, hold: 0};
        vecs[3] = '{value: 6'd9,  code: 24'h000_FFF, ovf: 1'b0, hold: 0};
        vecs[4] = '{value: 6'd50, code: 24'h0FF_000, ovf: 1'b0, hold: 5};
        vecs[5] = '{value: 6'd10, code: 24'hF00_000, ovf: 1'b0, hold: 0};
        vecs[6] = '{value: 6'd28, code: 24'hF80_F0F, ovf: 1'b0, hold: 0};
        vecs[7] = '{value: 6'd45, code: 24'h0F0_0FF, ovf: 1'b0, hold: 0};

        rst = 1'b1;
        in_valid_a = 1'b0; in_value_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; in_value_b = '0; out_ready_b = 1'b0;
        in_valid_c = 1'b0; in_value_c = '0; out_ready_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset a in_ready", 64'(in_ready_a), 64'd1);
        check("reset a out_valid", 64'(out_valid_a), 64'd0);
        check("reset a code", 64'(code_a), 64'd0);
        check("reset a ovf", 64'(ovf_a), 64'd0);
        check("reset b in_ready", 64'(in_ready_b), 64'd1);
        check("reset c code", 64'(code_c), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main table on the default instance; 0 and 63 run back-to-back
        for (int i = 0; i < 8; i++) begin
            xfer(0, 64'(vecs[i].value), 64'(vecs[i].code), vecs[i].ovf, 6, vecs[i].hold,
                 $sformatf("vec%0d(%0d)", i, vecs[i].value));
        end

        // Overflow on an 8-bit input
        xfer(1, 64'd150, 64'hFFF_FFF, 1'b1, 8, 0, "b 150");
        xfer(1, 64'd99,  64'hFFF_FFF, 1'b0, 8, 0, "b 99");
        xfer(1, 64'd200, 64'hFFF_FFF, 1'b1, 8, 2, "b 200");
        xfer(1, 64'd7,   64'h000_00F, 1'b0, 8, 0, "b 7");

        // 24-bit colours
        xfer(2, 64'd25, 64'hFF8800_00FFFF, 1'b0, 6, 0, "c 25");
        xfer(2, 64'd61, 64'h0088FF_FF0000, 1'b0, 6, 0, "c 61");

        // Asynchronous reset in the third CONV cycle of 45; code holds 0F00FF beforehand
        @(negedge clk);
        in_valid_a = 1'b1;
        in_value_a = 6'd45;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid_a), 64'd0);
        check("abort code", 64'(code_a), 64'd0);
        check("abort in_ready", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid_a) seen_valid = 1'b1;
        end
        check("abort no partial result", 64'(seen_valid), 64'd0);
        xfer(0, 64'd12, 64'hF00_F80, 1'b0, 6, 0, "after abort 12");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
